// File: rtl/combi_pkg.sv
// Shared types for the combined ARM/RISC-V pipeline: ALU opcodes, ARM
// condition codes, forwarding selects and the D/E pipeline register layout.
package combi_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  // Everything the decode stage hands to execute, captured as one word.
  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic              reg_write;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    logic              pc_src;
    logic              jump;
    logic [2:0]        alu_control;
    logic [1:0]        flag_write;
    logic [3:0]        cond;
    logic [1:0]        result_src;
  } de_reg_t;

endpackage

// File: rtl/stage_e_alu.sv
// Execute-stage ALU: add/sub share one 33-bit adder so the carry-out and
// signed overflow fall out of the same sum; logic ops and signed slt report
// C = V = 0.
module alu
  import combi_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_control,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v
);

  logic                     sub_op;
  logic                     arith;
  logic [DATA_W-1:0]        b_eff;
  logic [DATA_W:0]          sum;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic                     lt_signed;

  assign a_s       = a;
  assign b_s       = b;
  assign lt_signed = (a_s < b_s);

  // Subtraction is A + ~B + 1 so that C is the ARM "no borrow" carry.
  assign sub_op = (alu_control == ALU_SUB);
  assign b_eff  = sub_op ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_op};

  // Result mux; unlisted opcodes produce zero.
  always_comb begin
    result = '0;
    arith  = 1'b0;
    case (alu_control)
      ALU_ADD, ALU_SUB: begin
        result = sum[DATA_W-1:0];
        arith  = 1'b1;
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt_signed};
      default: result = '0;
    endcase
  end

  assign n = result[DATA_W-1];
  assign z = (result == '0);
  assign c = arith & sum[DATA_W];
  // Overflow: both adder inputs share a sign that the sum does not.
  assign v = arith & (a[DATA_W-1] == b_eff[DATA_W-1]) &
             (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/stage_e.sv
// Execute stage of the combined ARM/RISC-V core. Holds the D/E pipeline
// register, resolves operand forwarding, runs the ALU, decides branches and
// keeps the ARM NZCV flags. Side effects of an ARM instruction are gated by
// its condition check against the flags as they stand while it is in E.
module stage_e
  import combi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [31:0]       Rd1D,
  input  logic [31:0]       Rd2D,
  input  logic [31:0]       immextD,
  input  logic [31:0]       PCD,
  input  logic [31:0]       PCPlus4D,
  input  logic [4:0]        RdD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic              PCSrcD,
  input  logic              JumpD,
  input  logic [2:0]        ALUControlD,
  input  logic [1:0]        FlagWriteD,
  input  logic [3:0]        CondD,
  input  logic [1:0]        ResultSrcD,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [31:0]       ResultW,
  input  logic [31:0]       ALUResultM,
  input  logic              FlushE,
  output logic [31:0]       ALUResultE,
  output logic [31:0]       WriteDataE,
  output logic [31:0]       PCTargetE,
  output logic [31:0]       PCPlus4E,
  output logic [4:0]        RdE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              PCSrcE,
  output logic [1:0]        ResultSrcE
);

  de_reg_t           de_in;
  de_reg_t           de_p0;
  logic [3:0]        nzcv;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] alu_result;
  logic              flag_n;
  logic              flag_z;
  logic              flag_c;
  logic              flag_v;
  logic              cond_ex;

  // ARM condition decode against a packed {N,Z,C,V} word.
  function automatic logic cond_check(input logic [3:0] cond,
                                      input logic [3:0] flags);
    logic fn, fz, fc, fv, ok;
    {fn, fz, fc, fv} = flags;
    case (cond)
      COND_EQ: ok = fz;
      COND_NE: ok = ~fz;
      COND_CS: ok = fc;
      COND_CC: ok = ~fc;
      COND_MI: ok = fn;
      COND_PL: ok = ~fn;
      COND_VS: ok = fv;
      COND_VC: ok = ~fv;
      COND_HI: ok = fc & ~fz;
      COND_LS: ok = ~fc | fz;
      COND_GE: ok = (fn == fv);
      COND_LT: ok = (fn != fv);
      COND_GT: ok = ~fz & (fn == fv);
      COND_LE: ok = fz | (fn != fv);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Gather the decode-stage fields into the pipeline word.
  always_comb begin
    de_in             = '0;
    de_in.rd1         = Rd1D;
    de_in.rd2         = Rd2D;
    de_in.imm         = immextD;
    de_in.pc          = PCD;
    de_in.pc_plus4    = PCPlus4D;
    de_in.rd          = RdD;
    de_in.rs1         = Rs1D;
    de_in.rs2         = Rs2D;
    de_in.reg_write   = RegWriteD;
    de_in.mem_write   = MemWriteD;
    de_in.branch      = BranchD;
    de_in.alu_src     = ALUSrcD;
    de_in.pc_src      = PCSrcD;
    de_in.jump        = JumpD;
    de_in.alu_control = ALUControlD;
    de_in.flag_write  = FlagWriteD;
    de_in.cond        = CondD;
    de_in.result_src  = ResultSrcD;
  end

  // ---- D/E boundary: load every cycle; reset or flush inserts a bubble ----
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      de_p0 <= '0;
    end else begin
      de_p0 <= de_in;
    end
  end

  // Operand A forwarding; the unused 11 code falls back to the register.
  always_comb begin
    src_a = de_p0.rd1;
    case (ForwardAE)
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = de_p0.rd1;
    endcase
  end

  // Operand B forwarding; this value is also the store data.
  always_comb begin
    write_data = de_p0.rd2;
    case (ForwardBE)
      FWD_W:   write_data = ResultW;
      FWD_M:   write_data = ALUResultM;
      default: write_data = de_p0.rd2;
    endcase
  end

  assign src_b = de_p0.alu_src ? de_p0.imm : write_data;

  alu u_alu (
    .a           (src_a),
    .b           (src_b),
    .alu_control (de_p0.alu_control),
    .result      (alu_result),
    .n           (flag_n),
    .z           (flag_z),
    .c           (flag_c),
    .v           (flag_v)
  );

  // RISC-V has no predication, so every instruction executes.
  assign cond_ex = arm ? cond_check(de_p0.cond, nzcv) : 1'b1;

  // ---- E boundary: flags written by the instruction leaving E; a flush of
  // the incoming slot does not affect this, only reset clears the flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv <= 4'b0000;
    end else if (arm && cond_ex) begin
      if (de_p0.flag_write[1]) nzcv[3:2] <= {flag_n, flag_z};
      if (de_p0.flag_write[0]) nzcv[1:0] <= {flag_c, flag_v};
    end
  end

  assign ALUResultE = alu_result;
  assign WriteDataE = write_data;
  assign PCPlus4E   = de_p0.pc_plus4;
  assign RdE        = de_p0.rd;
  assign Rs1E       = de_p0.rs1;
  assign Rs2E       = de_p0.rs2;
  assign ResultSrcE = de_p0.result_src;
  assign RegWriteE  = de_p0.reg_write & cond_ex;
  assign MemWriteE  = de_p0.mem_write & cond_ex;

  // ARM branches compute their target in the ALU; RISC-V uses PC + imm and
  // only resolves beq (branch on zero) plus unconditional jumps here.
  assign PCTargetE = arm ? alu_result : (de_p0.pc + de_p0.imm);
  assign PCSrcE    = arm ? ((de_p0.pc_src | de_p0.branch) & cond_ex)
                         : (de_p0.jump | (de_p0.branch & flag_z));

endmodule

// File: tb/tb_stage_e.sv
// Bench for stage_e: ALU vector table, hand-written multi-cycle sequences
// for forwarding, flags, branches, flush and reset, then randomized traffic
// in both ISA modes against an arithmetic reference model.
module tb_stage_e;

  logic        clk = 1'b0;
  logic        rst, arm;
  logic [31:0] Rd1D, Rd2D, immextD, PCD, PCPlus4D;
  logic [4:0]  RdD, Rs1D, Rs2D;
  logic        RegWriteD, MemWriteD, BranchD, ALUSrcD, PCSrcD, JumpD;
  logic [2:0]  ALUControlD;
  logic [1:0]  FlagWriteD, ResultSrcD;
  logic [3:0]  CondD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW, ALUResultM;
  logic        FlushE;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, PCSrcE;
  logic [1:0]  ResultSrcE;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stage_e dut (
    .clk(clk), .rst(rst), .arm(arm),
    .Rd1D(Rd1D), .Rd2D(Rd2D), .immextD(immextD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .PCSrcD(PCSrcD), .JumpD(JumpD),
    .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
    .ResultSrcD(ResultSrcD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .ALUResultM(ALUResultM), .FlushE(FlushE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
    .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
    .ResultSrcE(ResultSrcE)
  );

  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, mw, br, alusrc, pcsrc, jump;
    logic [2:0]  ctl;
    logic [1:0]  fw, rs;
    logic [3:0]  cond;
  } dinst_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } alu_vec_t;

  function automatic dinst_t nop_d();
    dinst_t d;
    d.rd1 = 0; d.rd2 = 0; d.imm = 0; d.pc = 0; d.pc4 = 0;
    d.rd = 0; d.rs1 = 0; d.rs2 = 0;
    d.rw = 0; d.mw = 0; d.br = 0; d.alusrc = 0; d.pcsrc = 0; d.jump = 0;
    d.ctl = 0; d.fw = 0; d.rs = 0; d.cond = 4'b1110;
    return d;
  endfunction

  task automatic set_d(input dinst_t d);
    Rd1D = d.rd1; Rd2D = d.rd2; immextD = d.imm; PCD = d.pc; PCPlus4D = d.pc4;
    RdD = d.rd; Rs1D = d.rs1; Rs2D = d.rs2;
    RegWriteD = d.rw; MemWriteD = d.mw; BranchD = d.br; ALUSrcD = d.alusrc;
    PCSrcD = d.pcsrc; JumpD = d.jump; ALUControlD = d.ctl; FlagWriteD = d.fw;
    CondD = d.cond; ResultSrcD = d.rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic isa);
    arm = isa; rst = 1'b1; FlushE = 1'b0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0; ALUResultM = 0;
    set_d(nop_d());
    tick();
    rst = 1'b0;
  endtask

  // Reference ALU from plain integer arithmetic; returns {N,Z,C,V}.
  task automatic ref_alu(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output logic [3:0] f);
    longint sa, sb, sr;
    logic   c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 0; v = 0; r = 0; sr = 0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        sr = sa + sb;
        v  = (sr != longint'($signed(r)));
      end
      3'd1: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr != longint'($signed(r)));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 0;
    endcase
    f = {r[31], (r == 0), c, v};
  endtask

  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cc)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return ALUResultM;
    return reg_v;
  endfunction

  // Randomized run in one ISA mode, model tracks the E slot and NZCV.
  task automatic run_random(input logic isa, input int cycles);
    dinst_t      e, nd;
    logic [3:0]  nzcv, f;
    logic [31:0] a_v, b_v, srcb, r, exp_tgt;
    logic        ex, exp_pcsrc;
    do_reset(isa);
    e = nop_d(); e.cond = 4'b0000; nzcv = 4'b0000;
    for (int i = 0; i < cycles; i++) begin
      ForwardAE  = 2'($urandom_range(0, 3));
      ForwardBE  = 2'($urandom_range(0, 3));
      ResultW    = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      ALUResultM = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      #1;
      a_v  = pick(ForwardAE, e.rd1);
      b_v  = pick(ForwardBE, e.rd2);
      srcb = e.alusrc ? e.imm : b_v;
      ref_alu(e.ctl, a_v, srcb, r, f);
      ex = isa ? ref_cond(e.cond, nzcv) : 1'b1;
      exp_pcsrc = isa ? ((e.pcsrc | e.br) & ex) : (e.jump | (e.br & (r == 0)));
      exp_tgt   = isa ? r : e.pc + e.imm;
      check("rnd_alu", ALUResultE, r);
      check("rnd_wdata", WriteDataE, b_v);
      check("rnd_target", PCTargetE, exp_tgt);
      check("rnd_pcsrc", 32'(PCSrcE), 32'(exp_pcsrc));
      check("rnd_regwrite", 32'(RegWriteE), 32'(e.rw & ex));
      check("rnd_memwrite", 32'(MemWriteE), 32'(e.mw & ex));
      check("rnd_rd", 32'(RdE), 32'(e.rd));
      check("rnd_pc4", PCPlus4E, e.pc4);
      check("rnd_rsrc", 32'(ResultSrcE), 32'(e.rs));
      if (isa && ex) begin
        if (e.fw[1]) nzcv[3:2] = f[3:2];
        if (e.fw[0]) nzcv[1:0] = f[1:0];
      end
      nd.rd1    = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      nd.rd2    = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      nd.imm    = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      nd.pc     = $urandom; nd.pc4 = $urandom;
      nd.rd     = 5'($urandom); nd.rs1 = 5'($urandom); nd.rs2 = 5'($urandom);
      nd.rw     = 1'($urandom); nd.mw = 1'($urandom); nd.br = 1'($urandom);
      nd.alusrc = 1'($urandom); nd.pcsrc = ($urandom_range(0, 3) == 0);
      nd.jump   = ($urandom_range(0, 3) == 0);
      nd.ctl    = 3'($urandom); nd.fw = 2'($urandom);
      nd.rs     = 2'($urandom); nd.cond = 4'($urandom);
      set_d(nd);
      FlushE = ($urandom_range(0, 7) == 0);
      if (FlushE) begin
        e = nop_d(); e.cond = 4'b0000;
      end else begin
        e = nd;
      end
      tick();
    end
    FlushE = 1'b0;
  endtask

  initial begin
    alu_vec_t tbl[12];
    dinst_t   d;

    tbl[0]  = '{3'd0, 32'd3,         32'd4,         32'd7};
    tbl[1]  = '{3'd0, 32'hFFFF_FFFF, 32'd1,         32'd0};
    tbl[2]  = '{3'd1, 32'd3,         32'd5,         32'hFFFF_FFFE};
    tbl[3]  = '{3'd2, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000};
    tbl[4]  = '{3'd3, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0};
    tbl[5]  = '{3'd4, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0};
    tbl[6]  = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'd1};
    tbl[7]  = '{3'd5, 32'd1,         32'hFFFF_FFFF, 32'd0};
    tbl[8]  = '{3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
    tbl[9]  = '{3'd6, 32'd5,         32'd6,         32'd0};
    tbl[10] = '{3'd7, 32'd5,         32'd6,         32'd0};
    tbl[11] = '{3'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF};

    // Reset state
    arm = 1'b0; rst = 1'b1; FlushE = 1'b0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0; ALUResultM = 0;
    set_d(nop_d());
    tick(); tick();
    check("rst_alu", ALUResultE, 32'd0);
    check("rst_target", PCTargetE, 32'd0);
    check("rst_pcsrc", 32'(PCSrcE), 32'd0);
    check("rst_regwrite", 32'(RegWriteE), 32'd0);
    check("rst_rd", 32'(RdE), 32'd0);
    rst = 1'b0;

    // ALU vector table (RISC-V mode, register operands)
    for (int i = 0; i < 12; i++) begin
      d = nop_d();
      d.rd1 = tbl[i].a; d.rd2 = tbl[i].b; d.ctl = tbl[i].op;
      set_d(d);
      tick();
      check($sformatf("alu_tbl%0d", i), ALUResultE, tbl[i].res);
      check($sformatf("wdata_tbl%0d", i), WriteDataE, tbl[i].b);
    end

    // Forwarding from M plus immediate
    do_reset(1'b0);
    d = nop_d(); d.rd1 = 5; d.ctl = 3'd0; d.alusrc = 1; d.imm = 3;
    set_d(d);
    tick();
    ForwardAE = 2'b10; ALUResultM = 9;
    #1 check("fwd_m_add", ALUResultE, 32'd12);
    ForwardAE = 2'b01; ResultW = 20;
    #1 check("fwd_w_add", ALUResultE, 32'd23);
    ForwardAE = 2'b11;
    #1 check("fwd_11_reg", ALUResultE, 32'd8);
    ForwardAE = 2'b00;

    // ARM flags: 3-3 sets Z and C, then EQ executes, NE does not
    do_reset(1'b1);
    d = nop_d(); d.rd1 = 3; d.rd2 = 3; d.ctl = 3'd1; d.fw = 2'b11;
    set_d(d); tick();
    d = nop_d(); d.cond = 4'b0000; d.rw = 1; set_d(d); tick();
    check("arm_eq_exec", 32'(RegWriteE), 32'd1);
    d.cond = 4'b0001; set_d(d); tick();
    check("arm_ne_skip", 32'(RegWriteE), 32'd0);
    d.cond = 4'b0010; set_d(d); tick();
    check("arm_cs_exec", 32'(RegWriteE), 32'd1);
    d.cond = 4'b0100; set_d(d); tick();
    check("arm_mi_skip", 32'(RegWriteE), 32'd0);

    // Overflow: 0x7FFFFFFF + 1 leaves N=1 Z=0 C=0 V=1
    do_reset(1'b1);
    d = nop_d(); d.rd1 = 32'h7FFF_FFFF; d.rd2 = 1; d.ctl = 3'd0; d.fw = 2'b11;
    set_d(d); tick();
    check("ovf_result", ALUResultE, 32'h8000_0000);
    d = nop_d(); d.cond = 4'b1011; d.rw = 1; set_d(d); tick();
    check("ovf_lt_skip", 32'(RegWriteE), 32'd0);
    d.cond = 4'b0110; set_d(d); tick();
    check("ovf_vs_exec", 32'(RegWriteE), 32'd1);
    d.cond = 4'b0011; set_d(d); tick();
    check("ovf_cc_exec", 32'(RegWriteE), 32'd1);
    d.cond = 4'b1010; set_d(d); tick();
    check("ovf_ge_exec", 32'(RegWriteE), 32'd1);
    d.cond = 4'b1111; set_d(d); tick();
    check("ovf_nv_skip", 32'(RegWriteE), 32'd0);

    // RISC-V beq taken and not taken
    do_reset(1'b0);
    d = nop_d(); d.rd1 = 7; d.rd2 = 7; d.ctl = 3'd1; d.br = 1;
    d.pc = 32'h100; d.imm = 32'hFFFF_FFF8;
    set_d(d); tick();
    check("beq_taken", 32'(PCSrcE), 32'd1);
    check("beq_target", PCTargetE, 32'h0000_00F8);
    d.rd2 = 8; set_d(d); tick();
    check("beq_not_taken", 32'(PCSrcE), 32'd0);
    d = nop_d(); d.jump = 1; d.rd1 = 1; set_d(d); tick();
    check("jal_taken", 32'(PCSrcE), 32'd1);

    // Flush of a store while the flag-setting instruction in E retires
    do_reset(1'b1);
    d = nop_d(); d.rd1 = 3; d.rd2 = 3; d.ctl = 3'd1; d.fw = 2'b11;
    set_d(d); tick();
    d = nop_d(); d.mw = 1; d.rw = 1; d.rd = 5; set_d(d);
    FlushE = 1'b1; tick(); FlushE = 1'b0;
    check("flush_memwrite", 32'(MemWriteE), 32'd0);
    check("flush_regwrite", 32'(RegWriteE), 32'd0);
    check("flush_rd", 32'(RdE), 32'd0);
    d = nop_d(); d.cond = 4'b0000; d.rw = 1; set_d(d); tick();
    check("flush_flags_kept", 32'(RegWriteE), 32'd1);

    // Reset mid-stream with a pending ARM branch and nonzero flags
    do_reset(1'b1);
    d = nop_d(); d.rd1 = 3; d.rd2 = 3; d.ctl = 3'd1; d.fw = 2'b11;
    set_d(d); tick();
    d = nop_d(); d.br = 1; d.pcsrc = 1; d.rd = 7; d.rd1 = 32'h40; d.pc4 = 32'h44;
    set_d(d); tick();
    check("pre_rst_branch", 32'(PCSrcE), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_pcsrc", 32'(PCSrcE), 32'd0);
    check("mid_rst_alu", ALUResultE, 32'd0);
    check("mid_rst_target", PCTargetE, 32'd0);
    check("mid_rst_rd", 32'(RdE), 32'd0);
    check("mid_rst_pc4", PCPlus4E, 32'd0);
    d = nop_d(); d.cond = 4'b0000; d.rw = 1; set_d(d); tick();
    check("mid_rst_z_clear", 32'(RegWriteE), 32'd0);
    d.cond = 4'b0010; set_d(d); tick();
    check("mid_rst_c_clear", 32'(RegWriteE), 32'd0);

    // Randomized traffic in both modes
    run_random(1'b1, 400);
    run_random(1'b0, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
